vend_ctrl_multi: RTL

Parametrised successor to the single-item vending controller, with configurable item count, credit width, low-stock surcharge, cancel/refund and optional coin-by-coin change dispensing. It sits between the debouncers and the inventory, display and audio blocks in `vending_machine_top`. It takes 1-cycle coin, purchase and cancel pulses and drives vend and dispense pulses, credit, change and status outputs.

---
 rtl/vend_pkg.sv | 43 ++++
 rtl/vend_change_dispenser.sv | 49 ++++
 rtl/vend_ctrl_multi.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the multi-item vending controller: FSM state
// encoding, error codes, coin one-hot bit positions/values and the
// coin_value() decoder used by both the controller and the change dispenser.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_VEND   = 3'd2,
    ST_CHANGE = 3'd3,
    ST_THANK  = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE         = 2'd0;
  localparam logic [1:0] ERR_INSUFFICIENT = 2'd1;
  localparam logic [1:0] ERR_SOLD_OUT     = 2'd2;

  localparam int COIN_1_BIT = 0;
  localparam int COIN_2_BIT = 1;
  localparam int COIN_5_BIT = 2;

  localparam logic [2:0] COIN_1_VAL = 3'd1;
  localparam logic [2:0] COIN_2_VAL = 3'd2;
  localparam logic [2:0] COIN_5_VAL = 3'd5;

  // Dollar value of a one-hot coin vector; anything not one-hot is worth 0.
  function automatic logic [2:0] coin_value(input logic [2:0] coin);
    logic [2:0] value;
    value = 3'd0;
    if ($onehot(coin)) begin
      if (coin[COIN_5_BIT]) begin
        value = COIN_5_VAL;
      end else if (coin[COIN_2_BIT]) begin
        value = COIN_2_VAL;
      end else begin
        value = COIN_1_VAL;
      end
    end
    return value;
  endfunction

endpackage

// File: rtl/vend_change_dispenser.sv
// Greedy change dispenser: load captures the amount to pay out, then the
// largest coin that fits is offered on coin each cycle while the internal
// remainder counts down. done is high whenever nothing is left to pay.
module vend_change_dispenser
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [CREDIT_W-1:0] amount,
  output logic [2:0]          coin,
  output logic                done
);

  logic [CREDIT_W-1:0] remain_reg;
  logic [CREDIT_W-1:0] remain_next;
  logic [2:0]          coin_sel;

  // Pick the largest coin not exceeding the remainder and step the counter.
  always_comb begin
    coin_sel = 3'b000;
    if (remain_reg >= CREDIT_W'(COIN_5_VAL)) begin
      coin_sel[COIN_5_BIT] = 1'b1;
    end else if (remain_reg >= CREDIT_W'(COIN_2_VAL)) begin
      coin_sel[COIN_2_BIT] = 1'b1;
    end else if (remain_reg != '0) begin
      coin_sel[COIN_1_BIT] = 1'b1;
    end
    remain_next = remain_reg - CREDIT_W'(coin_value(coin_sel));
    if (load) begin
      remain_next = amount;
    end
  end

  // Remainder register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      remain_reg <= '0;
    end else begin
      remain_reg <= remain_next;
    end
  end

  assign coin = coin_sel;
  assign done = (remain_reg == '0);

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-item vending controller with low-stock surcharge, cancel/refund and
// carry-over credit. Define CHANGE_DISPENSE_EN to pay change out coin by
// coin through vend_change_dispenser; otherwise CHANGE lasts one cycle and
// the remainder stays as credit after a vend.
module vend_ctrl_multi
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS        = 4,
  parameter int CREDIT_W         = 8,
  parameter int STOCK_W          = 4,
  parameter int LOW_STOCK_THRESH = 1,
  parameter int SURCHARGE        = 1,
  parameter int THANK_YOU_CYCLES = 100000000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [2:0]                    coin_pulse,
  input  logic                          purchase,
  input  logic                          cancel,
  input  logic [$clog2(NUM_ITEMS)-1:0]  item_sel,
  input  logic [NUM_ITEMS*CREDIT_W-1:0] price_flat,
  input  logic [NUM_ITEMS*STOCK_W-1:0]  stock_flat,
  output logic [CREDIT_W-1:0]           credit,
  output logic [CREDIT_W-1:0]           change_due,
  output logic                          vend_pulse,
  output logic [$clog2(NUM_ITEMS)-1:0]  vend_item,
  output logic [2:0]                    dispense_coin,
  output logic                          coin_reject,
  output logic                          error_flag,
  output logic [1:0]                    err_code,
  output logic                          thank_you,
  output logic [2:0]                    state
);

  localparam int SEL_W = $clog2(NUM_ITEMS);
  localparam int SUM_W = CREDIT_W + 1;
  localparam int CNT_W = $clog2(THANK_YOU_CYCLES + 1);

  state_t              state_reg, state_next;
  logic [CREDIT_W-1:0] credit_reg, credit_next;
  logic [CREDIT_W-1:0] change_due_reg, change_due_next;
  logic                vend_pulse_reg, vend_pulse_next;
  logic [SEL_W-1:0]    vend_item_reg, vend_item_next;
  logic                coin_reject_reg, coin_reject_next;
  logic                error_flag_reg, error_flag_next;
  logic [1:0]          err_code_reg, err_code_next;
  logic                thank_you_reg, thank_you_next;
  logic [SEL_W-1:0]    item_reg, item_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;

  // Per-item views of the flattened price and stock buses.
  logic [CREDIT_W-1:0] price_arr [NUM_ITEMS];
  logic [STOCK_W-1:0]  stock_arr [NUM_ITEMS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ITEMS; gi++) begin : g_unpack
      assign price_arr[gi] = price_flat[gi*CREDIT_W +: CREDIT_W];
      assign stock_arr[gi] = stock_flat[gi*STOCK_W +: STOCK_W];
    end
  endgenerate

  logic [CREDIT_W-1:0] sel_price;
  logic [STOCK_W-1:0]  sel_stock;
  logic                low_stock;
  logic [SUM_W-1:0]    price_sum;
  logic [CREDIT_W-1:0] eff_price;

  // Effective price of the latched item, surcharge saturating at full scale.
  always_comb begin
    sel_price = price_arr[item_reg];
    sel_stock = stock_arr[item_reg];
    low_stock = (sel_stock <= STOCK_W'(LOW_STOCK_THRESH));
    price_sum = {1'b0, sel_price} + (low_stock ? SUM_W'(SURCHARGE) : SUM_W'(0));
    eff_price = price_sum[CREDIT_W] ? '1 : price_sum[CREDIT_W-1:0];
  end

  logic                coin_any;
  logic                coin_ok;
  logic [SUM_W-1:0]    coin_sum;
  logic [CREDIT_W-1:0] credit_in;

  // Coin acceptance: only in IDLE/THANK, single coin, no credit overflow.
  always_comb begin
    coin_any  = |coin_pulse;
    coin_sum  = {1'b0, credit_reg} + SUM_W'(coin_value(coin_pulse));
    coin_ok   = ((state_reg == ST_IDLE) || (state_reg == ST_THANK)) &&
                $onehot(coin_pulse) && !coin_sum[CREDIT_W];
    credit_in = coin_ok ? coin_sum[CREDIT_W-1:0] : credit_reg;
  end

`ifdef CHANGE_DISPENSE_EN
  logic                disp_load;
  logic [CREDIT_W-1:0] disp_amount;
  logic [2:0]          disp_coin;
  logic                disp_done;
  logic [2:0]          dispense_reg, dispense_next;
  logic [CREDIT_W-1:0] disp_val;

  vend_change_dispenser #(
    .CREDIT_W (CREDIT_W)
  ) u_dispenser (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (disp_load),
    .amount (disp_amount),
    .coin   (disp_coin),
    .done   (disp_done)
  );

  assign disp_val = CREDIT_W'(coin_value(disp_coin));
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_next       = state_reg;
    credit_next      = credit_in;
    change_due_next  = change_due_reg;
    vend_pulse_next  = 1'b0;
    vend_item_next   = vend_item_reg;
    coin_reject_next = coin_any && !coin_ok;
    error_flag_next  = 1'b0;
    err_code_next    = err_code_reg;
    thank_you_next   = 1'b0;
    item_next        = item_reg;
    cnt_next         = cnt_reg;
`ifdef CHANGE_DISPENSE_EN
    disp_load        = 1'b0;
    disp_amount      = '0;
    dispense_next    = 3'b000;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (cancel) begin
          // Refund everything held, including a coin arriving this cycle.
          if (credit_in != '0) begin
            state_next      = ST_CHANGE;
            change_due_next = credit_in;
`ifdef CHANGE_DISPENSE_EN
            disp_load       = 1'b1;
            disp_amount     = credit_in;
`else
            credit_next     = '0;
`endif
          end
        end else if (purchase) begin
          item_next     = item_sel;
          err_code_next = ERR_NONE;
          state_next    = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (sel_stock == '0) begin
          state_next      = ST_ERROR;
          error_flag_next = 1'b1;
          err_code_next   = ERR_SOLD_OUT;
        end else if (credit_reg < eff_price) begin
          state_next      = ST_ERROR;
          error_flag_next = 1'b1;
          err_code_next   = ERR_INSUFFICIENT;
        end else begin
          state_next      = ST_VEND;
          vend_pulse_next = 1'b1;
          vend_item_next  = item_reg;
          credit_next     = credit_reg - eff_price;
          change_due_next = credit_reg - eff_price;
        end
      end
      ST_VEND: begin
        state_next = ST_CHANGE;
`ifdef CHANGE_DISPENSE_EN
        disp_load   = 1'b1;
        disp_amount = credit_reg;
`endif
      end
      ST_CHANGE: begin
`ifdef CHANGE_DISPENSE_EN
        if (disp_done) begin
          state_next     = ST_THANK;
          thank_you_next = 1'b1;
          cnt_next       = '0;
        end else begin
          dispense_next   = disp_coin;
          credit_next     = credit_reg - disp_val;
          change_due_next = change_due_reg - disp_val;
        end
`else
        state_next     = ST_THANK;
        thank_you_next = 1'b1;
        cnt_next       = '0;
`endif
      end
      ST_THANK: begin
        if (cnt_reg == CNT_W'(THANK_YOU_CYCLES - 1)) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          thank_you_next = 1'b1;
          cnt_next       = cnt_reg + CNT_W'(1);
        end
      end
      ST_ERROR: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and output registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      credit_reg      <= '0;
      change_due_reg  <= '0;
      vend_pulse_reg  <= 1'b0;
      vend_item_reg   <= '0;
      coin_reject_reg <= 1'b0;
      error_flag_reg  <= 1'b0;
      err_code_reg    <= ERR_NONE;
      thank_you_reg   <= 1'b0;
      item_reg        <= '0;
      cnt_reg         <= '0;
    end else begin
      state_reg       <= state_next;
      credit_reg      <= credit_next;
      change_due_reg  <= change_due_next;
      vend_pulse_reg  <= vend_pulse_next;
      vend_item_reg   <= vend_item_next;
      coin_reject_reg <= coin_reject_next;
      error_flag_reg  <= error_flag_next;
      err_code_reg    <= err_code_next;
      thank_you_reg   <= thank_you_next;
      item_reg        <= item_next;
      cnt_reg         <= cnt_next;
    end
  end

`ifdef CHANGE_DISPENSE_EN
  // Change-coin pulse register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dispense_reg <= 3'b000;
    end else begin
      dispense_reg <= dispense_next;
    end
  end

  assign dispense_coin = dispense_reg;
`else
  assign dispense_coin = 3'b000;
`endif

  assign credit      = credit_reg;
  assign change_due  = change_due_reg;
  assign vend_pulse  = vend_pulse_reg;
  assign vend_item   = vend_item_reg;
  assign coin_reject = coin_reject_reg;
  assign error_flag  = error_flag_reg;
  assign err_code    = err_code_reg;
  assign thank_you   = thank_you_reg;
  assign state       = state_reg;

endmodule
